// File: rtl/llc_rst_flush_seq.sv
// LLC reset/flush sequencer: walks every set, writes back valid dirty data ways (flush only), then strobes the update stage once per set.
// Latency: rd_set_en 1 cycle after the request; 3 cycles per set with single-cycle acks, plus 1 cycle per write-back.
// Backpressure: rd_set_en held until rd_set_ack, wb_valid/wb_way held until wb_ready; pause parks the walk at a set boundary.
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   rst_req, flush_req       one-cycle requests to invalidate / write back and invalidate the LLC
//   pause                    hold the walk after the current set's update
//   busy, done               walk in progress; one-cycle pulse after the last set is updated
//   set                      set index owned by the sequencer while busy
//   rd_set_en, rd_set_ack    load request for `set` into the way buffers and its acknowledge
//   way_valid_data, way_dirty  per-way state vectors, valid on the rd_set_ack cycle
//   wb_valid, wb_way, wb_ready write-back request handshake for one way of `set`
//   update_en                one-cycle strobe to the update stage
//   is_rst_to_resume, is_flush_to_resume  update mode, qualified by update_en
module llc_rst_flush_seq #(
   parameter int SETS     = 256,
   parameter int WAYS     = 16,
   parameter int SET_BITS = $clog2(SETS),
   parameter int WAY_BITS = $clog2(WAYS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rst_req,
   input  logic                flush_req,
   input  logic                pause,
   output logic                busy,
   output logic                done,
   output logic [SET_BITS-1:0] set,
   output logic                rd_set_en,
   input  logic                rd_set_ack,
   input  logic [WAYS-1:0]     way_valid_data,
   input  logic [WAYS-1:0]     way_dirty,
   output logic                wb_valid,
   output logic [WAY_BITS-1:0] wb_way,
   input  logic                wb_ready,
   output logic                update_en,
   output logic                is_rst_to_resume,
   output logic                is_flush_to_resume
);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WB,
      UPDATE,
      DONE
   } state_t;

   typedef enum logic {
      MODE_RST,
      MODE_FLUSH
   } mode_t;

   localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(SETS - 1);

   state_t            state;
   mode_t             mode;
   logic [WAYS-1:0]   wb_mask;
   logic              pending;   // flush request waiting behind a reset walk
   logic              parked;    // UPDATE-exit hold: strobe already issued, waiting for pause to drop

   logic [WAYS-1:0]   cap_mask;
   logic [WAYS-1:0]   mask_clr;

   // Lowest set bit of a way mask; 0 for an empty mask so wb_way idles at 0.
   function automatic logic [WAY_BITS-1:0] lowest(input logic [WAYS-1:0] m);
      lowest = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (m[i]) lowest = WAY_BITS'(i);
      end
   endfunction

   // A reset walk never writes back, so its mask is forced empty at capture.
   always_comb begin
      cap_mask = '0;
      if (mode == MODE_FLUSH) cap_mask = way_valid_data & way_dirty;
      mask_clr = wb_mask & ~(WAYS'(1) << wb_way);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state              <= IDLE;
         mode               <= MODE_RST;
         set                <= '0;
         wb_mask            <= '0;
         pending            <= 1'b0;
         parked             <= 1'b0;
         busy               <= 1'b0;
         done               <= 1'b0;
         rd_set_en          <= 1'b0;
         wb_valid           <= 1'b0;
         wb_way             <= '0;
         update_en          <= 1'b0;
         is_rst_to_resume   <= 1'b0;
         is_flush_to_resume <= 1'b0;
      end else begin
         // Pulse outputs default low; transitions re-raise them for exactly one cycle.
         done               <= 1'b0;
         update_en          <= 1'b0;
         is_rst_to_resume   <= 1'b0;
         is_flush_to_resume <= 1'b0;

         if (state != IDLE && rst_req) begin
            // Reset wins over anything in flight: a flush is abandoned (its
            // write-back handshake included), a reset walk restarts at set 0.
            state     <= READ;
            mode      <= MODE_RST;
            set       <= '0;
            wb_mask   <= '0;
            wb_way    <= '0;
            parked    <= 1'b0;
            busy      <= 1'b1;
            rd_set_en <= 1'b1;
            wb_valid  <= 1'b0;
            if (mode == MODE_RST && flush_req) pending <= 1'b1;
         end else begin
            // One-deep flush queue behind a reset walk; a flush during a flush is dropped.
            if (state != IDLE && mode == MODE_RST && flush_req) pending <= 1'b1;

            case (state)
               IDLE: begin
                  if (rst_req) begin
                     state     <= READ;
                     mode      <= MODE_RST;
                     set       <= '0;
                     busy      <= 1'b1;
                     rd_set_en <= 1'b1;
                     if (flush_req) pending <= 1'b1;
                  end else if (flush_req || pending) begin
                     state     <= READ;
                     mode      <= MODE_FLUSH;
                     set       <= '0;
                     busy      <= 1'b1;
                     rd_set_en <= 1'b1;
                     pending   <= 1'b0;
                  end
               end

               READ: begin
                  if (rd_set_ack) begin
                     rd_set_en <= 1'b0;
                     wb_mask   <= cap_mask;
                     wb_way    <= lowest(cap_mask);
                     if (cap_mask != '0) begin
                        state    <= WB;
                        wb_valid <= 1'b1;
                     end else begin
                        state              <= UPDATE;
                        update_en          <= 1'b1;
                        is_rst_to_resume   <= (mode == MODE_RST);
                        is_flush_to_resume <= (mode == MODE_FLUSH);
                     end
                  end
               end

               WB: begin
                  if (wb_ready) begin
                     wb_mask <= mask_clr;
                     wb_way  <= lowest(mask_clr);
                     if (mask_clr == '0) begin
                        state              <= UPDATE;
                        wb_valid           <= 1'b0;
                        update_en          <= 1'b1;
                        is_rst_to_resume   <= (mode == MODE_RST);
                        is_flush_to_resume <= (mode == MODE_FLUSH);
                     end
                  end
               end

               UPDATE: begin
                  if (!parked) begin
                     // Strobe cycle: the set is complete, move on or finish.
                     if (set == LAST_SET) begin
                        state <= DONE;
                        done  <= 1'b1;
                     end else begin
                        set <= set + SET_BITS'(1);
                        if (pause) begin
                           parked <= 1'b1;
                        end else begin
                           state     <= READ;
                           rd_set_en <= 1'b1;
                        end
                     end
                  end else if (!pause) begin
                     parked    <= 1'b0;
                     state     <= READ;
                     rd_set_en <= 1'b1;
                  end
               end

               DONE: begin
                  // Set index wraps only here.
                  state <= IDLE;
                  busy  <= 1'b0;
                  set   <= '0;
               end

               default: begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  rd_set_en <= 1'b0;
                  wb_valid  <= 1'b0;
                  parked    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_llc_rst_flush_seq.sv
// Bench for llc_rst_flush_seq with 4 sets x 4 ways.
// Reference model: the expected event stream (write-backs in ascending way order, one update per set, then done) built from the per-set way vectors.
// Way-buffer and memory responders are modelled here with configurable or random latency.
module tb_llc_rst_flush_seq;

   localparam int SETS = 4;
   localparam int WAYS = 4;

   logic            clk;
   logic            rst;
   logic            rst_req;
   logic            flush_req;
   logic            pause;
   logic            busy;
   logic            done;
   logic [1:0]      set;
   logic            rd_set_en;
   logic            rd_set_ack;
   logic [WAYS-1:0] way_valid_data;
   logic [WAYS-1:0] way_dirty;
   logic            wb_valid;
   logic [1:0]      wb_way;
   logic            wb_ready;
   logic            update_en;
   logic            is_rst_to_resume;
   logic            is_flush_to_resume;

   llc_rst_flush_seq #(.SETS(SETS), .WAYS(WAYS)) dut (
      .clk                (clk),
      .rst                (rst),
      .rst_req            (rst_req),
      .flush_req          (flush_req),
      .pause              (pause),
      .busy               (busy),
      .done               (done),
      .set                (set),
      .rd_set_en          (rd_set_en),
      .rd_set_ack         (rd_set_ack),
      .way_valid_data     (way_valid_data),
      .way_dirty          (way_dirty),
      .wb_valid           (wb_valid),
      .wb_way             (wb_way),
      .wb_ready           (wb_ready),
      .update_en          (update_en),
      .is_rst_to_resume   (is_rst_to_resume),
      .is_flush_to_resume (is_flush_to_resume)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      bit          fl;
      logic [15:0] vd;
      logic [15:0] dt;
      int          exp_wb;
      int          exp_cyc;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [15:0] vd_all, dirty_all;
   int  ack_lat, cur_ack_lat, lat_cnt;
   int  rdy_lat, cur_rdy_lat, rdy_cnt;
   bit  ack_rand, rdy_rand, pause_rand;
   int  obs[$];
   int  exp_q[$];
   int  done_cyc[$];
   int  wbv_cycles;
   bit  prev_wbv, prev_hs;
   logic [1:0] prev_way;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int ev(input int t, input int s, input int w);
      return (t << 16) | (s << 8) | w;
   endfunction

   task automatic cfg(input int al, input int rl, input bit rnd);
      ack_lat     = al;
      cur_ack_lat = al;
      rdy_lat     = rl;
      cur_rdy_lat = rl;
      ack_rand    = rnd;
      rdy_rand    = rnd;
      pause_rand  = rnd;
      pause       = 1'b0;
   endtask

   // One clock: drive the responders for this cycle, then record DUT events.
   task automatic step();
      bit hs;
      int t;
      @(negedge clk);
      cyc++;
      if (prev_wbv && !prev_hs && wb_valid)
         check("wb_way_stable", int'(wb_way), int'(prev_way));

      if (rd_set_en && !rd_set_ack) begin
         lat_cnt++;
         if (lat_cnt > cur_ack_lat) begin
            rd_set_ack     = 1'b1;
            way_valid_data = vd_all[int'(set)*WAYS +: WAYS];
            way_dirty      = dirty_all[int'(set)*WAYS +: WAYS];
         end
      end else begin
         rd_set_ack     = 1'b0;
         lat_cnt        = 0;
         way_valid_data = WAYS'($urandom);
         way_dirty      = WAYS'($urandom);
         cur_ack_lat    = ack_rand ? int'($urandom_range(3, 1)) : ack_lat;
      end

      if (wb_valid) begin
         wb_ready = (rdy_cnt >= cur_rdy_lat);
         rdy_cnt++;
      end else begin
         wb_ready = 1'($urandom);
         rdy_cnt  = 0;
      end
      hs = wb_valid && wb_ready;
      if (hs) begin
         rdy_cnt     = 0;
         cur_rdy_lat = rdy_rand ? int'($urandom_range(2, 0)) : rdy_lat;
      end
      if (pause_rand) pause = ($urandom_range(3, 0) == 0);

      if (wb_valid) wbv_cycles++;
      if (hs) obs.push_back(ev(1, int'(set), int'(wb_way)));
      if (update_en) begin
         if (is_rst_to_resume && is_flush_to_resume) t = 5;
         else if (is_flush_to_resume) t = 3;
         else if (is_rst_to_resume) t = 2;
         else t = 6;
         obs.push_back(ev(t, int'(set), 0));
      end else if (is_rst_to_resume || is_flush_to_resume) begin
         obs.push_back(ev(7, int'(set), 0));
      end
      if (done) begin
         obs.push_back(ev(4, 0, 0));
         done_cyc.push_back(cyc);
      end
      prev_wbv = wb_valid;
      prev_hs  = hs;
      prev_way = wb_way;
   endtask

   // Reference: one walk of the whole cache from the per-set way vectors.
   task automatic build_exp(input bit fl);
      logic [WAYS-1:0] m;
      for (int s = 0; s < SETS; s++) begin
         m = vd_all[s*WAYS +: WAYS] & dirty_all[s*WAYS +: WAYS];
         if (fl) begin
            for (int w = 0; w < WAYS; w++)
               if (m[w]) exp_q.push_back(ev(1, s, w));
         end
         exp_q.push_back(ev(fl ? 3 : 2, s, 0));
      end
      exp_q.push_back(ev(4, 0, 0));
   endtask

   task automatic clear_obs();
      obs.delete();
      exp_q.delete();
      done_cyc.delete();
      wbv_cycles = 0;
   endtask

   task automatic cmp_events(input string name);
      int nbad;
      nbad = 0;
      check({name, "_len"}, obs.size(), exp_q.size());
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
         if (obs[i] != exp_q[i]) begin
            if (nbad == 0)
               $display("  %s first difference at event %0d: got 0x%0h, expected 0x%0h", name, i, obs[i], exp_q[i]);
            nbad++;
         end
      end
      check({name, "_event_diffs"}, nbad, 0);
   endtask

   function automatic int count_wb();
      int n;
      n = 0;
      foreach (obs[i]) if ((obs[i] >> 16) == 1) n++;
      return n;
   endfunction

   task automatic wait_done(input int start, input int n, input int budget);
      while (done_cyc.size() < n && cyc - start < budget) step();
   endtask

   task automatic run_walk(input bit fl, input int budget, output int cycles);
      int start;
      clear_obs();
      build_exp(fl);
      if (fl) flush_req = 1'b1;
      else rst_req = 1'b1;
      start = cyc;
      step();
      rst_req   = 1'b0;
      flush_req = 1'b0;
      check("busy_rise", busy, 1);
      check("rd_set_en_first", rd_set_en, 1);
      wait_done(start, 1, budget);
      check("done_seen", done_cyc.size(), 1);
      cycles = (done_cyc.size() > 0) ? done_cyc[0] - start : -1;
      step();
      check("busy_fall", busy, 0);
      cmp_events(fl ? "flush_walk" : "rst_walk");
   endtask

   vec_t tab[6];
   int   cycles, start, found, nrd, nupd, nbusy;

   initial begin
      tab[0] = '{1'b0, 16'hFFFF, 16'hFFFF, 0, 13};
      tab[1] = '{1'b1, 16'h0000, 16'hFFFF, 0, 13};
      tab[2] = '{1'b1, 16'hFFFF, 16'hFFFF, 16, 29};
      tab[3] = '{1'b1, 16'h0060, 16'h0030, 1, 14};
      tab[4] = '{1'b1, 16'h8421, 16'h8421, 4, 17};
      tab[5] = '{1'b1, 16'hF0F0, 16'h0FF0, 4, 17};

      rst = 1'b0; rst_req = 1'b0; flush_req = 1'b0; pause = 1'b0;
      rd_set_ack = 1'b0; wb_ready = 1'b0; way_valid_data = '0; way_dirty = '0;
      vd_all = '0; dirty_all = '0; lat_cnt = 0; rdy_cnt = 0;
      prev_wbv = 1'b0; prev_hs = 1'b0; prev_way = '0;
      cfg(1, 0, 1'b0);
      clear_obs();

      // Reset state
      repeat (3) step();
      check("rst_outputs", int'({busy, done, rd_set_en, wb_valid, update_en,
                                  is_rst_to_resume, is_flush_to_resume, set, wb_way}), 0);
      rst = 1'b1;
      repeat (2) step();
      check("idle_busy", busy, 0);
      check("idle_set", int'(set), 0);

      // Table of zero-wait walks with known cycle and write-back counts
      for (int i = 0; i < 6; i++) begin
         vd_all    = tab[i].vd;
         dirty_all = tab[i].dt;
         cfg(1, 0, 1'b0);
         run_walk(tab[i].fl, 200, cycles);
         check($sformatf("tab%0d_cycles", i), cycles, tab[i].exp_cyc);
         check($sformatf("tab%0d_wb_count", i), count_wb(), tab[i].exp_wb);
      end

      // Write-back held with wb_ready low for 3 cycles
      vd_all = 16'h0060; dirty_all = 16'h0030;
      cfg(1, 3, 1'b0);
      run_walk(1'b1, 200, cycles);
      check("held_wb_valid_cycles", wbv_cycles, 4);
      check("held_cycles", cycles, 17);

      // Simultaneous requests: reset walk, then the pending flush
      vd_all = 16'hFFFF; dirty_all = 16'h00F0;
      cfg(1, 0, 1'b0);
      clear_obs();
      build_exp(1'b0);
      build_exp(1'b1);
      rst_req = 1'b1; flush_req = 1'b1;
      start = cyc;
      step();
      rst_req = 1'b0; flush_req = 1'b0;
      wait_done(start, 2, 300);
      check("simul_done_count", done_cyc.size(), 2);
      if (done_cyc.size() == 2) begin
         check("simul_first_done", done_cyc[0] - start, 13);
         check("simul_second_done", done_cyc[1] - start, 31);
      end
      repeat (4) step();
      check("simul_idle_after", busy, 0);
      cmp_events("simul");

      // Reset request aborts a flush in the middle of a write-back at set 2
      vd_all = 16'hFFFF; dirty_all = 16'hFFFF;
      cfg(1, 2, 1'b0);
      clear_obs();
      flush_req = 1'b1;
      start = cyc;
      step();
      flush_req = 1'b0;
      found = 0;
      while (!found && cyc - start < 200) begin
         step();
         if (wb_valid && set == 2'd2) found = 1;
      end
      check("abort_reached_set2_wb", found, 1);
      clear_obs();
      build_exp(1'b0);
      rst_req = 1'b1;
      start = cyc;
      step();
      rst_req = 1'b0;
      check("abort_wb_valid", wb_valid, 0);
      check("abort_set", int'(set), 0);
      check("abort_rd_set_en", rd_set_en, 1);
      wait_done(start, 1, 200);
      check("abort_done", done_cyc.size(), 1);
      step();
      cmp_events("abort");

      // Pause after the set 1 update
      cfg(1, 0, 1'b0);
      clear_obs();
      build_exp(1'b0);
      rst_req = 1'b1;
      start = cyc;
      step();
      rst_req = 1'b0;
      found = 0;
      while (!found && cyc - start < 100) begin
         step();
         if (update_en && set == 2'd1) found = 1;
      end
      check("pause_reached_set1_update", found, 1);
      pause = 1'b1;
      nrd = 0; nupd = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         nrd  += int'(rd_set_en);
         nupd += int'(update_en);
      end
      pause = 1'b0;
      check("pause_no_rd_set_en", nrd, 0);
      check("pause_no_update", nupd, 0);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (rd_set_en) found = 1;
      end
      check("pause_resume_read", found, 1);
      check("pause_resume_set", int'(set), 2);
      wait_done(start, 1, 200);
      step();
      cmp_events("pause");

      // Reset asserted during a write-back at set 3
      vd_all = 16'hFFFF; dirty_all = 16'hFFFF;
      cfg(1, 2, 1'b0);
      clear_obs();
      flush_req = 1'b1;
      start = cyc;
      step();
      flush_req = 1'b0;
      found = 0;
      while (!found && cyc - start < 200) begin
         step();
         if (wb_valid && set == 2'd3) found = 1;
      end
      check("rstmid_reached_set3_wb", found, 1);
      rst = 1'b0;
      step();
      check("rstmid_outputs", int'({busy, done, rd_set_en, wb_valid, update_en,
                                     is_rst_to_resume, is_flush_to_resume, set, wb_way}), 0);
      rst = 1'b1;
      nbusy = 0;
      repeat (3) begin
         step();
         nbusy += int'(busy);
      end
      check("rstmid_stays_idle", nbusy, 0);

      // Randomized walks: random way vectors, ack/ready latencies and pause
      for (int it = 0; it < 8; it++) begin
         vd_all    = 16'($urandom);
         dirty_all = 16'($urandom);
         cfg(1, 0, 1'b1);
         run_walk(it % 3 != 0, 2000, cycles);
         pause_rand = 1'b0;
         pause      = 1'b0;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
